// File: rtl/fwd_scoreboard_if.sv
// Bundles the EX-stage producer/consumer signals and the forwarding results of fwd_scoreboard.
// The master side drives the pipeline state; the slave side (the scoreboard) returns selects, the stall and the stall count.
interface fwd_scoreboard_if #(
    parameter int RF_SIZE = 5,
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 32
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic                       adv;
    logic                       flush;
    logic                       ex_valid;
    logic                       ex_regw;
    logic [RF_SIZE-1:0]         ex_rd;
    logic                       ex_is_load;
    logic                       ld_done;
    logic [NUM_SRC-1:0]         src_en;
    logic [NUM_SRC*RF_SIZE-1:0] src_idx;
    logic [NUM_SRC*SELW-1:0]    fwd_sel;
    logic                       hazard_stall;
    logic [CNT_W-1:0]           stall_cnt;

    modport master (
        output adv, flush, ex_valid, ex_regw, ex_rd, ex_is_load, ld_done, src_en, src_idx,
        input  fwd_sel, hazard_stall, stall_cnt
    );

    modport slave (
        input  adv, flush, ex_valid, ex_regw, ex_rd, ex_is_load, ld_done, src_en, src_idx,
        output fwd_sel, hazard_stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks DEPTH post-EX register writers and picks per-source bypass selects.
// Latency: selects and stall are combinational from registered entries; entries update on the edge after adv/ld_done.
// Backpressure: raises hazard_stall while the youngest matching producer is an outstanding load; caller holds EX.
module fwd_scoreboard #(
    parameter int RF_SIZE = 5,
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    fwd_scoreboard_if.slave sb
);
    localparam int SELW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic               valid;
        logic [RF_SIZE-1:0] rd;
        logic               is_load;
        logic               ready;
    } ent_t;

    ent_t                    ent_q [DEPTH];
    ent_t                    ent_d [DEPTH];
    logic [CNT_W-1:0]        stall_cnt_q;
    logic [CNT_W-1:0]        stall_cnt_d;
    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    hazard;
    logic [SELW-1:0]         sel;
    logic                    pend;
    logic [RF_SIZE-1:0]      idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
        if (sb.adv) begin
            for (int i = 1; i < DEPTH; i++) begin
                ent_d[i] = ent_q[i-1];
                // A load whose data arrives on the advancing cycle leaves entry 0 already ready.
                if (i == 1) ent_d[i].ready = ent_q[0].ready | sb.ld_done;
            end
            ent_d[0].valid   = sb.ex_valid & sb.ex_regw & (sb.ex_rd != '0) & ~sb.flush;
            ent_d[0].rd      = sb.ex_rd;
            ent_d[0].is_load = sb.ex_is_load;
            ent_d[0].ready   = ~sb.ex_is_load;
        end else if (sb.ld_done & ent_q[0].valid & ent_q[0].is_load) begin
            ent_d[0].ready = 1'b1;
        end
    end

    always_comb begin
        fwd_sel = '0;
        hazard  = 1'b0;
        sel     = '0;
        pend    = 1'b0;
        idx     = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            sel  = '0;
            pend = 1'b0;
            idx  = sb.src_idx[s*RF_SIZE +: RF_SIZE];
            // Scan oldest to youngest so the youngest producer overrides.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_q[k].valid && ent_q[k].rd == idx && idx != '0 && sb.src_en[s]) begin
                    sel  = SELW'(k + 1);
                    pend = ~ent_q[k].ready;
                end
            end
            fwd_sel[s*SELW +: SELW] = sel;
            hazard                  = hazard | pend;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb.fwd_sel      = fwd_sel;
    assign sb.hazard_stall = hazard;
    assign sb.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized traffic against a queue-based model.
module tb_fwd_scoreboard;
    localparam int RF      = 5;
    localparam int NSRC    = 3;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int SELW    = $clog2(DEPTH + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fwd_scoreboard_if #(.RF_SIZE(RF), .NUM_SRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    fwd_scoreboard #(.RF_SIZE(RF), .NUM_SRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: list of in-flight writes, youngest first; one record pushed per advance.
    typedef struct {
        bit valid;
        int rd;
        bit load;
        bit ready;
    } rec_t;

    rec_t q[$];
    int   m_cnt;

    function automatic void mexp(input int s, output int sel, output bit st);
        int  idx;
        bit  en;
        idx = int'(bus.src_idx[s*RF +: RF]);
        en  = bus.src_en[s];
        sel = 0;
        st  = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].valid && q[k].rd == idx && idx != 0 && en) begin
                sel = k + 1;
                st  = !q[k].ready;
                break;
            end
        end
    endfunction

    function automatic bit model_hazard();
        int sel;
        bit st;
        bit h;
        h = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            mexp(s, sel, st);
            h = h | st;
        end
        return h;
    endfunction

    function automatic void model_clock();
        rec_t r;
        if (model_hazard() && m_cnt < CNT_MAX) m_cnt++;
        if (bus.adv) begin
            if (q.size() > 0 && bus.ld_done) q[0].ready = 1'b1;
            r.valid = bus.ex_valid && bus.ex_regw && bus.ex_rd != 0 && !bus.flush;
            r.rd    = int'(bus.ex_rd);
            r.load  = bus.ex_is_load;
            r.ready = !bus.ex_is_load;
            q.push_front(r);
            if (q.size() > DEPTH) void'(q.pop_back());
        end else if (q.size() > 0 && bus.ld_done && q[0].valid && q[0].load) begin
            q[0].ready = 1'b1;
        end
    endfunction

    function automatic int get_sel(input int s);
        return int'(bus.fwd_sel[s*SELW +: SELW]);
    endfunction

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input bit w, input int rd, input bit ld);
        bus.ex_valid   = v;
        bus.ex_regw    = w;
        bus.ex_rd      = RF'(rd);
        bus.ex_is_load = ld;
    endtask

    task automatic set_src(input int s, input bit en, input int idx);
        bus.src_en[s]          = en;
        bus.src_idx[s*RF +: RF] = RF'(idx);
    endtask

    task automatic clear_inputs();
        bus.adv     = 1'b0;
        bus.flush   = 1'b0;
        bus.ld_done = 1'b0;
        bus.src_en  = '0;
        bus.src_idx = '0;
        set_ex(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        q.delete();
        m_cnt = 0;
        set_src(0, 1, 5);
        set_src(1, 1, 9);
        @(posedge clk);
        #1;
        checks++;
        if (get_sel(0) !== 0) begin errors++; $display("FAIL reset_sel0: got %0d expected 0", get_sel(0)); end
        checks++;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.hazard_stall); end
        checks++;
        if (bus.stall_cnt !== 0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.stall_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ex(1, 1, 5, 0);
        bus.adv = 1'b1;
        tick();
        set_ex(0, 0, 0, 0);
        set_src(0, 1, 5);
        #1;
        checks++;
        if (get_sel(0) !== 1) begin errors++; $display("FAIL b2b_sel_t1: got %0d expected 1", get_sel(0)); end
        checks++;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", bus.hazard_stall); end
        tick();
        #1;
        checks++;
        if (get_sel(0) !== 2) begin errors++; $display("FAIL b2b_sel_t2: got %0d expected 2", get_sel(0)); end
    endtask

    task automatic test_priority();
        do_reset();
        bus.adv = 1'b1;
        set_ex(1, 1, 7, 0);
        tick();
        tick();
        set_ex(0, 0, 0, 0);
        bus.adv = 1'b0;
        set_src(0, 1, 7);
        #1;
        checks++;
        if (get_sel(0) !== 1) begin errors++; $display("FAIL prio_youngest: got %0d expected 1", get_sel(0)); end
        set_ex(1, 1, 0, 0);
        bus.adv = 1'b1;
        tick();
        set_ex(0, 0, 0, 0);
        bus.adv = 1'b0;
        set_src(1, 1, 0);
        #1;
        checks++;
        if (get_sel(1) !== 0) begin errors++; $display("FAIL prio_x0: got %0d expected 0", get_sel(1)); end
        checks++;
        if (get_sel(0) !== 2) begin errors++; $display("FAIL prio_older: got %0d expected 2", get_sel(0)); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_ex(1, 1, 9, 1);
        bus.adv = 1'b1;
        tick();
        set_ex(0, 0, 0, 0);
        bus.adv = 1'b0;
        set_src(0, 1, 9);
        for (int c = 0; c < 3; c++) begin
            bus.ld_done = (c == 2);
            #1;
            checks++;
            if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_c%0d: got %b expected 1", c, bus.hazard_stall); end
            checks++;
            if (get_sel(0) !== 1) begin errors++; $display("FAIL lu_sel_c%0d: got %0d expected 1", c, get_sel(0)); end
            checks++;
            if (bus.stall_cnt !== CNT_W'(c)) begin errors++; $display("FAIL lu_cnt_c%0d: got %0d expected %0d", c, bus.stall_cnt, c); end
            tick();
        end
        bus.ld_done = 1'b0;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", bus.hazard_stall); end
        checks++;
        if (bus.stall_cnt !== 3) begin errors++; $display("FAIL lu_cnt_final: got %0d expected 3", bus.stall_cnt); end
    endtask

    task automatic test_adv_ld_done();
        do_reset();
        set_ex(1, 1, 9, 1);
        bus.adv = 1'b1;
        tick();
        set_ex(0, 0, 0, 0);
        bus.ld_done = 1'b1;
        set_src(0, 1, 9);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL ald_pre_stall: got %b expected 1", bus.hazard_stall); end
        tick();
        bus.adv     = 1'b0;
        bus.ld_done = 1'b0;
        #1;
        checks++;
        if (get_sel(0) !== 2) begin errors++; $display("FAIL ald_sel: got %0d expected 2", get_sel(0)); end
        checks++;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL ald_stall: got %b expected 0", bus.hazard_stall); end
        tick();
        checks++;
        if (bus.stall_cnt !== 1) begin errors++; $display("FAIL ald_cnt: got %0d expected 1", bus.stall_cnt); end
    endtask

    task automatic test_flush_disable();
        do_reset();
        set_ex(1, 1, 3, 0);
        bus.flush = 1'b1;
        bus.adv   = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.adv   = 1'b0;
        set_ex(0, 0, 0, 0);
        set_src(0, 1, 3);
        #1;
        checks++;
        if (get_sel(0) !== 0) begin errors++; $display("FAIL flush_bubble: got %0d expected 0", get_sel(0)); end
        set_ex(1, 1, 3, 0);
        bus.adv = 1'b1;
        tick();
        set_ex(0, 0, 0, 0);
        bus.adv = 1'b0;
        set_src(0, 0, 3);
        set_src(1, 1, 3);
        #1;
        checks++;
        if (get_sel(0) !== 0) begin errors++; $display("FAIL dis_sel: got %0d expected 0", get_sel(0)); end
        checks++;
        if (get_sel(1) !== 1) begin errors++; $display("FAIL en_sel: got %0d expected 1", get_sel(1)); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        checks++;
        if (get_sel(1) !== 1) begin errors++; $display("FAIL flush_noadv: got %0d expected 1", get_sel(1)); end
        set_ex(1, 1, 4, 1);
        bus.adv = 1'b1;
        tick();
        set_ex(0, 0, 0, 0);
        bus.adv = 1'b0;
        set_src(1, 0, 0);
        set_src(0, 0, 4);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL dis_load_stall: got %b expected 0", bus.hazard_stall); end
    endtask

    task automatic test_random();
        int sel;
        bit st;
        bit h;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.adv     = ($urandom_range(0, 3) != 0);
            bus.ld_done = ($urandom_range(0, 2) == 0);
            bus.flush   = ($urandom_range(0, 7) == 0);
            for (int s = 0; s < NSRC; s++) set_src(s, ($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)));
            h = model_hazard();
            set_ex(h ? 1'b0 : 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            #1;
            for (int s = 0; s < NSRC; s++) begin
                mexp(s, sel, st);
                checks++;
                if (get_sel(s) !== sel) begin errors++; $display("FAIL rnd_sel%0d n=%0d: got %0d expected %0d", s, n, get_sel(s), sel); end
            end
            checks++;
            if (bus.hazard_stall !== h) begin errors++; $display("FAIL rnd_stall n=%0d: got %b expected %b", n, bus.hazard_stall, h); end
            checks++;
            if (bus.stall_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt n=%0d: got %0d expected %0d", n, bus.stall_cnt, m_cnt); end
            tick();
        end
    endtask

    task automatic test_sat_reset();
        do_reset();
        set_ex(1, 1, 9, 1);
        bus.adv = 1'b1;
        tick();
        set_ex(0, 0, 0, 0);
        bus.adv = 1'b0;
        set_src(0, 1, 9);
        repeat (20) tick();
        #1;
        checks++;
        if (bus.stall_cnt !== CNT_W'(CNT_MAX)) begin errors++; $display("FAIL sat_cnt: got %0d expected %0d", bus.stall_cnt, CNT_MAX); end
        checks++;
        if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b expected 1", bus.hazard_stall); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b expected 0", bus.hazard_stall); end
        checks++;
        if (bus.stall_cnt !== 0) begin errors++; $display("FAIL arst_cnt: got %0d expected 0", bus.stall_cnt); end
        checks++;
        if (get_sel(0) !== 0) begin errors++; $display("FAIL arst_sel: got %0d expected 0", get_sel(0)); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_cnt = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_priority();
        test_load_use();
        test_adv_ld_done();
        test_flush_disable();
        test_random();
        test_sat_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the integer pipeline. It tracks in-flight register writes in a DEPTH-entry shadow pipeline covering the stages after EX. Each cycle it produces a forwarding select for each of NUM_SRC EX-stage source operands, and raises a stall when the nearest producer is a load whose data has not yet returned. It generalises fixed two-stage MEM/WB forwarding to arbitrary depth and source count, suppresses x0 forwarding, supports multi-cycle loads, and counts stall cycles.

## Interface
- RF_SIZE, 5: register index width.
- NUM_SRC, 3: number of EX source operands (rs1, rs2, store data).
- DEPTH, 2: tracked post-EX stages; entry 0 is the stage just after EX, entry DEPTH-1 is the oldest (writeback).
- SELW, $clog2(DEPTH+1): select width (localparam).
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- adv  in  1  post-EX pipeline advances this cycle.
- flush  in  1  the EX instruction is killed; a bubble enters entry 0 on advance.
- ex_valid  in  1  EX holds a real instruction.
- ex_regw  in  1  EX instruction writes rd.
- ex_rd  in  RF_SIZE  EX destination index.
- ex_is_load  in  1  EX instruction is a load.
- ld_done  in  1  load data for the entry 0 load is available this cycle.
- src_en  in  NUM_SRC  per-source "operand used" flag.
- src_idx  in  NUM_SRC*RF_SIZE  per-source register index; source s occupies bits [s*RF_SIZE +: RF_SIZE].
- fwd_sel  out  NUM_SRC*SELW  per-source select: 0 = register file, k = forward from entry k-1.
- hazard_stall  out  1  at least one enabled source depends on a not-ready load.
- stall_cnt  out  CNT_W  count of cycles with hazard_stall=1.

## Operation
- State per entry: valid, rd, is_load, ready.
- On reset, all entries are invalid and stall_cnt is 0. Because no entry is valid, fwd_sel is 0 and hazard_stall is 0.
- When adv=1:
  - entry[i] <= entry[i-1] for i≥1.
  - entry 1 takes ready = entry0.ready | ld_done.
  - entry 0 loads valid = ex_valid & ex_regw & (ex_rd≠0) & ~flush, with rd = ex_rd, is_load = ex_is_load, ready = ~ex_is_load.
  - The oldest entry retires.
- When adv=0, all entries hold. ld_done=1 sets entry0.ready if entry 0 is a valid load.
- ld_done is ignored when entry 0 is invalid or is not a load.
- Match rule for source s:
  - Entry k matches when entry k is valid, its rd equals src_idx[s], src_idx[s]≠0, and src_en[s]=1.
  - The lowest k among matching entries wins (youngest producer), so fwd_sel[s] = k+1.
  - With no match, fwd_sel[s] = 0.
- Hazard: hazard_stall = OR over s of (a winning match exists and that entry's ready=0). The select is still reported during a stall.
- Counter: stall_cnt increments by 1 on every cycle with hazard_stall=1 and saturates at all-ones. Only reset clears it.
- Caller contract: while hazard_stall=1, drive ex_valid=0 (or hold EX) so that no duplicate producer is recorded.

## Timing
- fwd_sel and hazard_stall are combinational from registered entries and the current src_en/src_idx, with zero-cycle latency.
- Entry updates take effect on the clock edge after adv/ld_done are sampled.
- A producer in EX at cycle t is visible as fwd_sel=1 for a consumer in EX at cycle t+1, given adv=1 at t.
- adv=1 together with ld_done=1 moves the load to entry 1 as ready. No stall is seen on the following cycle.
- flush=1 together with adv=1 inserts a bubble. flush with adv=0 has no effect.
- rst_n asserted mid-operation immediately clears all entries, drops hazard_stall, and zeroes stall_cnt.

## Test plan
- Back-to-back ALU dependency (DEPTH=2): ALU write x5 at t with adv=1, consumer reads x5 on src 0 at t+1 -> fwd_sel[0]=1, hazard_stall=0. At t+2 with no new producer -> fwd_sel[0]=2.
- Priority: x7 written by entries 0 and 1 -> fwd_sel=1 (youngest wins). Reading x0 with x0 marked as written -> fwd_sel=0.
- Load-use with 3-cycle memory: load x9 enters entry 0, consumer reads x9, adv=0 -> hazard_stall=1 for 3 cycles and stall_cnt=3. ld_done on cycle 3 -> hazard_stall=0 on the next cycle.
- Same-cycle adv+ld_done: load x9 in entry 0, both asserted -> entry 1 ready, consumer reading x9 gets fwd_sel=2 with no stall.
- Flush and disabled sources: flush=1, adv=1 with ex_rd=x3 -> no x3 match next cycle. A match with src_en=0 -> fwd_sel=0, no stall.
- Reset mid-stall and counter saturation (CNT_W=4): hold a hazard for 20 cycles -> stall_cnt=15. Pulse rst_n low -> entries empty, hazard_stall=0, stall_cnt=0 with no clock edge.
